systolic_skew_feeder: RTL and testbench



---
 rtl/systolic_skew_feeder.sv | 167 ++++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
//
// Upstream stage of systolic_array. Loads one N x N data tile (A) and one
// N x N weight tile (B) over a valid/ready interface, one column of A and one
// row of B per beat, then replays them into the array in diagonally skewed
// order (lane i delayed by i cycles). A one-cycle clear pulse precedes each
// stream and a one-cycle done pulse follows it.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   in_valid     load beat offered
//   in_ready     load beat accepted when in_valid && in_ready
//   in_data      beat k: byte lane i = A[i][k]
//   in_weight    beat k: byte lane j = B[k][j]
//   array_clear  one-cycle pulse that zeroes the array accumulators
//   out_valid    a stream step is present on datain/weightin
//   datain       skewed A lanes to systolic_array.datain
//   weightin     skewed B lanes to systolic_array.weightin
//   done         one-cycle pulse after the last stream step
//
// All outputs are registered: the combinational processes compute the value
// each output takes in the next cycle from the next state.

module systolic_skew_feeder #(
  parameter int array_size = 3,
  localparam int data_size = 8 * array_size
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [data_size-1:0] in_data,
  input  logic [data_size-1:0] in_weight,
  output logic                 array_clear,
  output logic                 out_valid,
  output logic [data_size-1:0] datain,
  output logic [data_size-1:0] weightin,
  output logic                 done
);

  // Stream steps run 0 .. 3N-3; beats run 0 .. N-1.
  localparam int last_step = 3 * array_size - 3;
  localparam int step_w    = $clog2(3 * array_size - 1);
  localparam int beat_w    = (array_size > 1) ? $clog2(array_size) : 1;

  typedef enum logic [1:0] {
    LOAD,
    CLEAR,
    STREAM,
    DONE
  } state_t;

  state_t              state, state_next;
  logic [beat_w-1:0]   beat, beat_next;
  logic [step_w-1:0]   step, step_next;

  logic [7:0] a_buf [array_size][array_size];  // a_buf[row][col] = A
  logic [7:0] b_buf [array_size][array_size];  // b_buf[row][col] = B

  logic                 accept;
  logic                 in_ready_next;
  logic                 array_clear_next;
  logic                 out_valid_next;
  logic                 done_next;
  logic [data_size-1:0] datain_next;
  logic [data_size-1:0] weightin_next;
  logic [beat_w-1:0]    k_idx;

  // in_ready is only ever high in LOAD, so a handshake implies LOAD.
  assign accept = in_valid && in_ready;

  // State register plus registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD;
      beat        <= '0;
      step        <= '0;
      in_ready    <= 1'b0;
      array_clear <= 1'b0;
      out_valid   <= 1'b0;
      done        <= 1'b0;
      datain      <= '0;
      weightin    <= '0;
    end else begin
      state       <= state_next;
      beat        <= beat_next;
      step        <= step_next;
      in_ready    <= in_ready_next;
      array_clear <= array_clear_next;
      out_valid   <= out_valid_next;
      done        <= done_next;
      datain      <= datain_next;
      weightin    <= weightin_next;
    end
  end

  // NOTE: tile buffers carry no reset; a stale tile is never streamed because
  // the FSM only reaches STREAM after N fresh beats have been written.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      for (int i = 0; i < array_size; i++) begin
        a_buf[i][beat] <= in_data[8*i +: 8];
        b_buf[beat][i] <= in_weight[8*i +: 8];
      end
    end
  end

  // Next-state logic.
  // NOTE: every signal gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    beat_next  = beat;
    step_next  = step;
    unique case (state)
      LOAD: begin
        if (accept) begin
          if (beat == beat_w'(array_size - 1)) begin
            state_next = CLEAR;
            beat_next  = '0;
          end else begin
            beat_next = beat + beat_w'(1);
          end
        end
      end
      CLEAR: begin
        state_next = STREAM;
        step_next  = '0;
      end
      STREAM: begin
        if (step == step_w'(last_step)) begin
          state_next = DONE;
        end else begin
          step_next = step + step_w'(1);
        end
      end
      DONE: begin
        state_next = LOAD;
        beat_next  = '0;
      end
      default: state_next = LOAD;
    endcase
  end

  // Output decode for the next cycle. On step s, lane i carries the element
  // with inner index s-i when that index lies in 0..N-1, otherwise zero.
  always_comb begin
    in_ready_next    = (state_next == LOAD);
    array_clear_next = (state_next == CLEAR);
    out_valid_next   = (state_next == STREAM);
    done_next        = (state_next == DONE);
    datain_next      = '0;
    weightin_next    = '0;
    k_idx            = '0;
    if (state_next == STREAM) begin
      for (int i = 0; i < array_size; i++) begin
        k_idx = beat_w'(int'(step_next) - i);
        if (int'(step_next) >= i && int'(step_next) - i < array_size) begin
          datain_next[8*i +: 8]   = a_buf[i][k_idx];
          weightin_next[8*i +: 8] = b_buf[k_idx][i];
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder (N = 3).
// Inputs are driven and outputs sampled on the falling clock edge. The
// expected stream is built by delaying each lane of the intended tile by its
// lane index; a behavioural output-stationary array fed from the DUT lanes
// must accumulate exactly A x B.

module tb_systolic_skew_feeder;

  localparam int n     = 3;
  localparam int dw    = 8 * n;
  localparam int steps = 3 * n - 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [dw-1:0] in_data = '0;
  logic [dw-1:0] in_weight = '0;
  logic          array_clear;
  logic          out_valid;
  logic [dw-1:0] datain;
  logic [dw-1:0] weightin;
  logic          done;

  int checks = 0;
  int failures = 0;

  // Tile the bench intends the DUT to hold: ta = A, tw = B.
  logic [7:0] ta [n][n];
  logic [7:0] tw [n][n];

  always #5 clk = ~clk;

  systolic_skew_feeder #(.array_size(n)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_weight   (in_weight),
    .array_clear (array_clear),
    .out_valid   (out_valid),
    .datain      (datain),
    .weightin    (weightin),
    .done        (done)
  );

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "watchdog");
  end

  task automatic set_tile_basic();
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        ta[i][j] = 8'(i * n + j + 1);
        tw[i][j] = (i == j) ? 8'd1 : 8'd0;
      end
  endtask

  task automatic set_tile_random();
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        ta[i][j] = 8'($urandom);
        tw[i][j] = 8'($urandom);
      end
  endtask

  task automatic set_tile_const(input logic [7:0] av, input logic [7:0] bv);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        ta[i][j] = av;
        tw[i][j] = bv;
      end
  endtask

  task automatic drive_beat(input int k);
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_data[8*i +: 8]   = ta[i][k];
      in_weight[8*i +: 8] = tw[k][i];
    end
  endtask

  // Loads beats 0..nbeats-1 of the intended tile. Returns on the falling edge
  // right after the last accepting rising edge.
  task automatic load_tile(input int nbeats, input int gap_beat, input int gap_len,
                           input bit random_gaps, input bit hold_last);
    for (int k = 0; k < nbeats; k++) begin
      int waited;
      int g;
      waited = 0;
      drive_beat(k);
      while (in_ready !== 1'b1 && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL load_wait beat=%0d in_ready=%b required 1", k, in_ready);
      end
      @(negedge clk);
      if (!(hold_last && k == nbeats - 1)) in_valid = 1'b0;
      if (k < nbeats - 1) begin
        g = (k == gap_beat) ? gap_len : 0;
        if (random_gaps) g = int'($urandom_range(0, 2));
        repeat (g) @(negedge clk);
      end
    end
  endtask

  // Entered on the falling edge of the CLEAR cycle. Checks the clear pulse,
  // every stream step, the done pulse and the return of in_ready.
  task automatic expect_stream(input string tag);
    logic [7:0]    exp_d [n][steps];
    logic [7:0]    exp_w [n][steps];
    logic [7:0]    ap [n][n];
    logic [7:0]    bp [n][n];
    int            acc [n][n];
    int            prod;
    logic [dw-1:0] ed, ew;

    for (int i = 0; i < n; i++) begin
      for (int s = 0; s < steps; s++) begin
        exp_d[i][s] = 8'd0;
        exp_w[i][s] = 8'd0;
      end
      for (int j = 0; j < n; j++) begin
        ap[i][j] = 8'd0;
        bp[i][j] = 8'd0;
        acc[i][j] = 0;
      end
    end
    // Lane i carries its N operands delayed by i steps.
    for (int i = 0; i < n; i++)
      for (int k = 0; k < n; k++) begin
        exp_d[i][i + k] = ta[i][k];
        exp_w[i][i + k] = tw[k][i];
      end

    checks++;
    if ({array_clear, out_valid, in_ready, done} !== 4'b1000) begin
      failures++;
      $display("FAIL %s clear_flags clear/valid/ready/done=%b required 1000", tag,
               {array_clear, out_valid, in_ready, done});
    end
    checks++;
    if ({datain, weightin} !== '0) begin
      failures++;
      $display("FAIL %s clear_lanes datain=%h weightin=%h required 0", tag, datain, weightin);
    end

    for (int s = 0; s < steps; s++) begin
      @(negedge clk);
      ed = '0;
      ew = '0;
      for (int i = 0; i < n; i++) begin
        ed[8*i +: 8] = exp_d[i][s];
        ew[8*i +: 8] = exp_w[i][s];
      end
      checks++;
      if ({out_valid, array_clear, in_ready, done} !== 4'b1000) begin
        failures++;
        $display("FAIL %s step%0d_flags valid/clear/ready/done=%b required 1000", tag, s,
                 {out_valid, array_clear, in_ready, done});
      end
      checks++;
      if (datain !== ed) begin
        failures++;
        $display("FAIL %s step%0d_datain got=%h required=%h", tag, s, datain, ed);
      end
      checks++;
      if (weightin !== ew) begin
        failures++;
        $display("FAIL %s step%0d_weightin got=%h required=%h", tag, s, weightin, ew);
      end
      // Behavioural array: A flows right, B flows down, each PE accumulates.
      for (int i = 0; i < n; i++)
        for (int j = n - 1; j > 0; j--) ap[i][j] = ap[i][j-1];
      for (int i = n - 1; i > 0; i--)
        for (int j = 0; j < n; j++) bp[i][j] = bp[i-1][j];
      for (int i = 0; i < n; i++) begin
        ap[i][0] = datain[8*i +: 8];
        bp[0][i] = weightin[8*i +: 8];
      end
      for (int i = 0; i < n; i++)
        for (int j = 0; j < n; j++) acc[i][j] += int'(ap[i][j]) * int'(bp[i][j]);
    end

    @(negedge clk);
    checks++;
    if ({done, out_valid, array_clear, in_ready} !== 4'b1000) begin
      failures++;
      $display("FAIL %s done_flags done/valid/clear/ready=%b required 1000", tag,
               {done, out_valid, array_clear, in_ready});
    end
    checks++;
    if ({datain, weightin} !== '0) begin
      failures++;
      $display("FAIL %s done_lanes datain=%h weightin=%h required 0", tag, datain, weightin);
    end
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        prod = 0;
        for (int k = 0; k < n; k++) prod += int'(ta[i][k]) * int'(tw[k][j]);
        checks++;
        if (acc[i][j] !== prod) begin
          failures++;
          $display("FAIL %s mac[%0d][%0d] got=%h required=%h", tag, i, j, acc[i][j], prod);
        end
      end

    @(negedge clk);
    checks++;
    if ({in_ready, done, out_valid} !== 3'b100) begin
      failures++;
      $display("FAIL %s reload ready/done/valid=%b required 100", tag,
               {in_ready, done, out_valid});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, array_clear, out_valid, done} !== 4'b0000 || {datain, weightin} !== '0) begin
      failures++;
      $display("FAIL reset_values ready/clear/valid/done=%b lanes=%h required all 0",
               {in_ready, array_clear, out_valid, done}, {datain, weightin});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    set_tile_basic();
    load_tile(n, -1, 0, 1'b0, 1'b0);
    expect_stream("basic");
  endtask

  task automatic test_gaps();
    set_tile_basic();
    load_tile(n, 0, 2, 1'b0, 1'b0);
    expect_stream("gaps");
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      set_tile_random();
      load_tile(n, -1, 0, 1'b1, 1'b0);
      expect_stream("random");
    end
  endtask

  task automatic test_back_to_back();
    set_tile_basic();
    load_tile(n, -1, 0, 1'b0, 1'b1);
    // Offer tile 2 beat 0 while tile 1 streams; it must wait for LOAD.
    for (int i = 0; i < n; i++) begin
      in_data[8*i +: 8]   = 8'hFF;
      in_weight[8*i +: 8] = 8'h01;
    end
    expect_stream("b2b_first");
    set_tile_const(8'hFF, 8'h01);
    load_tile(n, -1, 0, 1'b0, 1'b0);
    expect_stream("b2b_second");
  endtask

  task automatic test_reset_mid_stream();
    bit saw_done;
    int waited;
    set_tile_random();
    load_tile(n, -1, 0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);  // now in step 3
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_stream step3_valid out_valid=%b required 1", out_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, done, array_clear, in_ready} !== 4'b0000 || {datain, weightin} !== '0) begin
      failures++;
      $display("FAIL rst_stream after valid/done/clear/ready=%b lanes=%h required all 0",
               {out_valid, done, array_clear, in_ready}, {datain, weightin});
    end
    reset = 1'b0;
    saw_done = 1'b0;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
      waited++;
    end
    checks++;
    if (in_ready !== 1'b1 || saw_done) begin
      failures++;
      $display("FAIL rst_stream recover in_ready=%b saw_done=%b required 1/0", in_ready, saw_done);
    end
    set_tile_basic();
    load_tile(n, -1, 0, 1'b0, 1'b0);
    expect_stream("rst_stream_reload");
  endtask

  task automatic test_reset_mid_load();
    set_tile_random();
    load_tile(2, -1, 0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_load in_ready=%b required 0", in_ready);
    end
    reset = 1'b0;
    set_tile_basic();
    load_tile(n, -1, 0, 1'b0, 1'b0);
    expect_stream("rst_load_reload");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_random();
    test_back_to_back();
    test_reset_mid_stream();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
